// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM state encoding and op-class helper shared by the ALU files
package alu_seq_pkg;
    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_NOT  = 4'd2;
    localparam logic [3:0] OP_NEG  = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_MUL  = 4'd6;
    localparam logic [3:0] OP_DIV  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_SHRA = 4'd9;
    localparam logic [3:0] OP_SHL  = 4'd10;
    localparam logic [3:0] OP_ROR  = 4'd11;
    localparam logic [3:0] OP_ROL  = 4'd12;
    localparam logic [3:0] OP_INCB = 4'd13;
    localparam logic [3:0] OP_PASSA = 4'd14;
    localparam logic [3:0] OP_RSVD = 4'd15;

    typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_FIX} state_t;

    function automatic logic is_multi(input logic [3:0] op);
        return op == OP_MUL || op == OP_DIV;
    endfunction
endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: start/ready/done request bus between the control unit and the ALU
interface alu_seq_if #(parameter int WIDTH = 32);
    logic                   start;
    logic [3:0]             op;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   ready;
    logic                   done;
    logic [2*WIDTH-1:0]     result;
    logic                   flag_z;
    logic                   flag_n;
    logic                   flag_c;
    logic                   flag_v;
    logic                   flag_dbz;

    modport master (
        output start, op, a, b,
        input  ready, done, result, flag_z, flag_n, flag_c, flag_v, flag_dbz
    );
    modport slave (
        input  start, op, a, b,
        output ready, done, result, flag_z, flag_n, flag_c, flag_v, flag_dbz
    );
endinterface

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: iterative Booth radix-2 multiplier and non-restoring divider on one shared adder
module alu_seq_muldiv #(parameter int WIDTH = 32) (
    input  logic             i_clock,
    input  logic             i_clear_n,
    input  logic             i_load,
    input  logic             i_div,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic             o_n,
    output logic             o_v,
    output logic             o_dbz,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int SHW = $clog2(WIDTH);

    logic             r_div;
    logic             r_q1;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH:0]   r_acc;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH:0]   w_op;
    logic [WIDTH:0]   w_x;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_mac;
    logic             w_sub;

    assign w_a_mag = i_a[WIDTH-1] ? -i_a : i_a;
    assign w_d     = r_b[WIDTH-1] ? -r_b : r_b;
    // Divide works on magnitudes; the partial remainder shifts in the next dividend bit
    assign w_op  = r_div ? {r_acc[WIDTH-1:0], r_q[WIDTH-1]} : r_acc;
    assign w_x   = r_div ? {1'b0, w_d} : {r_a[WIDTH-1], r_a};
    assign w_sub = r_div ? ~r_acc[WIDTH] : (r_q[0] & ~r_q1);
    assign w_sum = w_op + (w_sub ? ~w_x : w_x) + {{WIDTH{1'b0}}, w_sub};
    assign w_mac = (r_q[0] ^ r_q1) ? w_sum : r_acc;
    assign o_last = &r_cnt;

    assign w_rem = r_acc[WIDTH] ? r_acc[WIDTH-1:0] + w_d : r_acc[WIDTH-1:0];
    assign o_dbz = r_div && r_b == '0;
    assign o_v   = r_div && r_a == {1'b1, {(WIDTH-1){1'b0}}} && &r_b;
    assign o_lo  = !r_div ? r_q : o_dbz ? '1 : (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? -r_q : r_q;
    assign o_hi  = !r_div ? r_acc[WIDTH-1:0] : o_dbz ? r_a : r_a[WIDTH-1] ? -w_rem : w_rem;
    assign o_n   = r_div ? o_lo[WIDTH-1] : o_hi[WIDTH-1];

    always_ff @(posedge i_clock or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_div <= 1'b0;
            r_q1  <= 1'b0;
            r_a   <= '0;
            r_b   <= '0;
            r_q   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_div <= i_div;
            r_q1  <= 1'b0;
            r_a   <= i_a;
            r_b   <= i_b;
            r_q   <= i_div ? w_a_mag : i_b;
            r_acc <= '0;
            r_cnt <= '0;
        end else if (i_step) begin
            r_cnt <= r_cnt + SHW'(1);
            r_acc <= r_div ? w_sum : {w_mac[WIDTH], w_mac[WIDTH:1]};
            r_q   <= r_div ? {r_q[WIDTH-2:0], ~w_sum[WIDTH]} : {w_mac[0], r_q[WIDTH-1:1]};
            r_q1  <= r_q[0];
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with single-cycle logic/arith/shift ops and iterative MUL/DIV
module alu_seq import alu_seq_pkg::*; #(parameter int WIDTH = 32) (
    input  logic     i_clock,
    input  logic     i_clear_n,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_nx;
    logic               r_done;
    logic [2*WIDTH-1:0] r_result;
    logic               r_z;
    logic               r_n;
    logic               r_c;
    logic               r_v;
    logic               r_dbz;
    logic               w_accept;
    logic               w_md;
    logic               w_md_last;
    logic               w_md_n;
    logic               w_md_v;
    logic               w_md_dbz;
    logic [WIDTH-1:0]   w_md_hi;
    logic [WIDTH-1:0]   w_md_lo;
    logic [SHW-1:0]     w_sh;
    logic [SHW-1:0]     w_shn;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH:0]     w_inc;
    logic [WIDTH-1:0]   w_neg;
    logic [WIDTH-1:0]   w_lo;
    logic               w_c;
    logic               w_v;

    assign w_md      = is_multi(bus.op);
    assign w_accept  = bus.start && bus.ready;
    assign bus.ready = r_state == ST_IDLE;
    assign bus.done  = r_done;
    assign bus.result = r_result;
    assign bus.flag_z = r_z;
    assign bus.flag_n = r_n;
    assign bus.flag_c = r_c;
    assign bus.flag_v = r_v;
    assign bus.flag_dbz = r_dbz;

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .i_clock  (i_clock),
        .i_clear_n(i_clear_n),
        .i_load   (w_accept && w_md),
        .i_div    (bus.op == OP_DIV),
        .i_step   (r_state == ST_ITER),
        .i_a      (bus.a),
        .i_b      (bus.b),
        .o_last   (w_md_last),
        .o_n      (w_md_n),
        .o_v      (w_md_v),
        .o_dbz    (w_md_dbz),
        .o_hi     (w_md_hi),
        .o_lo     (w_md_lo)
    );

    // Rotates take the complementary amount modulo WIDTH so amount 0 needs no special case
    assign w_sh  = bus.b[SHW-1:0];
    assign w_shn = -w_sh;
    assign w_add = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_sub = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
    assign w_inc = {1'b0, bus.b} + {{WIDTH{1'b0}}, 1'b1};
    assign w_neg = -bus.b;

    always_comb begin
        w_lo = '0;
        w_c  = 1'b0;
        w_v  = 1'b0;
        case (bus.op)
            OP_AND:   w_lo = bus.a & bus.b;
            OP_OR:    w_lo = bus.a | bus.b;
            OP_NOT:   w_lo = ~bus.b;
            OP_NEG: begin
                w_lo = w_neg;
                w_v  = bus.b[WIDTH-1] & w_neg[WIDTH-1];
            end
            OP_ADD: begin
                w_lo = w_add[WIDTH-1:0];
                w_c  = w_add[WIDTH];
                w_v  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_add[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                w_lo = w_sub[WIDTH-1:0];
                w_c  = w_sub[WIDTH];
                w_v  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_sub[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SHR:   w_lo = bus.a >> w_sh;
            OP_SHRA:  w_lo = $signed(bus.a) >>> w_sh;
            OP_SHL:   w_lo = bus.a << w_sh;
            OP_ROR:   w_lo = (bus.a >> w_sh) | (bus.a << w_shn);
            OP_ROL:   w_lo = (bus.a << w_sh) | (bus.a >> w_shn);
            OP_INCB: begin
                w_lo = w_inc[WIDTH-1:0];
                w_c  = w_inc[WIDTH];
            end
            OP_PASSA: w_lo = bus.a;
            default:  w_lo = '0;
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_state_nx = r_state == ST_IDLE ? (w_accept && w_md ? ST_ITER : ST_IDLE) :
                     r_state == ST_ITER ? (w_md_last ? ST_FIX : ST_ITER) : ST_IDLE;
    end

    always_ff @(posedge i_clock or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge i_clock or negedge i_clear_n) begin
        if (!i_clear_n) begin
            r_done   <= 1'b0;
            r_result <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_dbz    <= 1'b0;
        end else if (r_state == ST_FIX) begin
            r_done   <= 1'b1;
            r_result <= {w_md_hi, w_md_lo};
            r_z      <= w_md_lo == '0;
            r_n      <= w_md_n;
            r_c      <= 1'b0;
            r_v      <= w_md_v;
            r_dbz    <= w_md_dbz;
        end else if (w_accept && !w_md) begin
            r_done   <= 1'b1;
            r_result <= {{WIDTH{1'b0}}, w_lo};
            r_z      <= w_lo == '0;
            r_n      <= w_lo[WIDTH-1];
            r_c      <= w_c;
            r_v      <= w_v;
            r_dbz    <= 1'b0;
        end else begin
            r_done   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed checks of alu_seq against a plain-arithmetic model
module tb_alu_seq;
    import alu_seq_pkg::*;
    localparam int W = 32;
    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -MAXI - 1;
    localparam longint TWO32 = 64'sh1_0000_0000;

    logic clk = 1'b0;
    logic clear_n = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.i_clock(clk), .i_clear_n(clear_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [69:0] got, input logic [69:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {z, n, c, v, dbz, hi, lo}
    function automatic logic [68:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, t;
        logic [31:0] lo, hi;
        logic c, v, dbz, n;
        int s;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        lo = '0;
        hi = '0;
        c = 1'b0;
        v = 1'b0;
        dbz = 1'b0;
        s = int'(ub % 32);
        case (op)
            0: lo = a & b;
            1: lo = a | b;
            2: lo = ~b;
            3: begin t = -sb; lo = t[31:0]; v = t > MAXI; end
            4: begin t = sa + sb; lo = t[31:0]; v = t > MAXI || t < MINI; c = (ua + ub) >= TWO32; end
            5: begin t = sa - sb; lo = t[31:0]; v = t > MAXI || t < MINI; c = a >= b; end
            6: begin t = sa * sb; {hi, lo} = t; end
            7: begin
                if (b == 0) begin
                    lo = '1;
                    hi = a;
                    dbz = 1'b1;
                end else begin
                    t = sa / sb;
                    lo = t[31:0];
                    v = t > MAXI;
                    t = sa % sb;
                    hi = t[31:0];
                end
            end
            8: lo = a >> s;
            9: begin t = sa >>> s; lo = t[31:0]; end
            10: lo = a << s;
            11: begin lo = a; repeat (s) lo = {lo[0], lo[31:1]}; end
            12: begin lo = a; repeat (s) lo = {lo[30:0], lo[31]}; end
            13: begin t = ub + 1; lo = t[31:0]; c = t == TWO32; end
            14: lo = a;
            default: lo = '0;
        endcase
        n = (op == 6) ? hi[31] : lo[31];
        return {lo == 0, n, c, v, dbz, hi, lo};
    endfunction

    function automatic logic [68:0] observed();
        return {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.flag_dbz, bus.result};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Issues one op at a negedge; returns at the negedge where done is seen
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit junk);
        int lat;
        bit md;
        md = op == OP_MUL || op == OP_DIV;
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 40) begin
            if (lat == 2) chk("busy_ready", bus.ready, 1'b0);
            bus.start = junk && lat == 5;
            bus.op = junk ? OP_ADD : 4'($urandom);
            bus.a = $urandom;
            bus.b = $urandom;
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        chk("latency", lat, md ? 34 : 1);
        chk($sformatf("op%0d a=%h b=%h", op, a, b), observed(), model(op, a, b));
    endtask

    initial begin
        int highs;
        logic [63:0] held;
        bus.start = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        @(negedge clk);
        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_obs", observed(), '0);
        clear_n = 1'b1;
        @(negedge clk);

        run_op(OP_ADD, 32'h7FFFFFFF, 32'h1, 1'b0);
        chk("add_flags_vnc", {bus.flag_v, bus.flag_n, bus.flag_c}, 3'b110);
        run_op(OP_MUL, 32'hFFFFFFFB, 32'd7, 1'b1);
        chk("mul_lit", bus.result, 64'hFFFFFFFF_FFFFFFDD);
        held = bus.result;
        @(negedge clk);
        chk("done_pulse", bus.done, 1'b0);
        chk("result_held", bus.result, held);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        chk("div_lit", bus.result, 64'hFFFFFFFF_FFFFFFFD);
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        chk("div_ovf", {bus.flag_v, bus.result}, {1'b1, 64'h00000000_80000000});
        run_op(OP_DIV, 32'd9, 32'd0, 1'b1);
        chk("div_dbz", {bus.flag_dbz, bus.result}, {1'b1, 64'h00000009_FFFFFFFF});
        run_op(OP_ROL, 32'h80000001, 32'd33, 1'b0);
        chk("rol_lit", bus.result, 64'h3);
        run_op(OP_SHRA, 32'h80000000, 32'd4, 1'b0);
        chk("shra_lit", bus.result, 64'hF8000000);
        run_op(OP_RSVD, 32'h12345678, 32'h9ABCDEF0, 1'b0);
        chk("rsvd_lit", bus.result, 64'h0);

        for (int i = 0; i < 300; i++) begin
            run_op(4'($urandom_range(0, 15)), pick(), pick(), 1'($urandom_range(0, 1)));
        end

        bus.start = 1'b1;
        bus.op = OP_DIV;
        bus.a = 32'd1000;
        bus.b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        clear_n = 1'b0;
        #1;
        chk("abort_ready", bus.ready, 1'b1);
        chk("abort_obs", {bus.done, observed()}, '0);
        @(negedge clk);
        clear_n = 1'b1;
        highs = 0;
        repeat (40) begin
            @(negedge clk);
            highs += int'(bus.done);
        end
        chk("abort_no_done", highs, 0);
        run_op(OP_SUB, 32'd5, 32'd9, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
